// File: rtl/mem_pkg.sv
// Shared memory-access definitions for the RV32I datapath: Funct3 size/sign
// encodings and the responder FSM state type.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  // Byte lane a naturally aligned access starts at, in bits.
  function automatic logic [4:0] lane_shift(input logic [1:0] offset);
    return {offset, 3'b000};
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational lane selector: picks the byte/half/word addressed by offset out
// of a 32-bit RAM word and extends it, and reports whether the access is legal
// (valid Funct3 for the operation and naturally aligned). The store path uses
// the same block for its byte enables and legality check.
import mem_pkg::*;

module load_align (
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  input  logic        is_store,
  output logic [31:0] data,
  output logic [3:0]  byte_en,
  output logic        legal
);

  logic [31:0] shifted;

  assign shifted = word >> lane_shift(offset);

  // Size/sign decode, extension and byte-enable generation
  always_comb begin
    data    = '0;
    byte_en = '0;
    legal   = 1'b0;
    unique case (funct3)
      F3_B: begin
        legal   = 1'b1;
        data    = {{24{shifted[7]}}, shifted[7:0]};
        byte_en = 4'b0001 << offset;
      end
      F3_BU: begin
        legal   = ~is_store;
        data    = {24'h0, shifted[7:0]};
        byte_en = 4'b0001 << offset;
      end
      F3_H: begin
        legal   = ~offset[0];
        data    = {{16{shifted[15]}}, shifted[15:0]};
        byte_en = 4'b0011 << {offset[1], 1'b0};
      end
      F3_HU: begin
        legal   = ~is_store & ~offset[0];
        data    = {16'h0, shifted[15:0]};
        byte_en = 4'b0011 << {offset[1], 1'b0};
      end
      F3_W: begin
        legal   = (offset == 2'b00);
        data    = word;
        byte_en = 4'b1111;
      end
      default: begin
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: word-organised RAM with byte/half/word loads and
// stores, a fixed access latency, and a one-cycle Ready (and Err on reject)
// pulse the core can stall on.
import mem_pkg::*;

module data_mem_responder #(
  parameter int unsigned ADDR_W  = 9,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  Funct3,
  input  logic [31:0] Addr,
  input  logic [31:0] WrData,
  output logic [31:0] RdData,
  output logic        Ready,
  output logic        Err
);

  localparam int unsigned DEPTH    = 2 ** ADDR_W;
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  state_t              state;
  logic [3:0]          cnt;

  logic [ADDR_W-1:0]   idx_q;
  logic [1:0]          off_q;
  logic [2:0]          f3_q;
  logic [31:0]         wdata_q;
  logic                rd_q;
  logic                wr_q;

  logic [31:0]         mem [DEPTH];

  logic [31:0]         mem_word;
  logic [31:0]         ld_data;
  logic [31:0]         wr_shifted;
  logic [3:0]          byte_en;
  logic                acc_legal;
  logic                reject;
  logic                fire;
  logic                we;
  logic                start;
  logic                unused_addr;

  // Address bits above the word index alias by design.
  assign unused_addr = ^Addr[31:ADDR_W+2];

  assign start      = (state == IDLE) && (MemRead || MemWrite);
  assign fire       = (state == BUSY) && (cnt == 4'd0);
  assign mem_word   = mem[idx_q];
  assign wr_shifted = wdata_q << lane_shift(off_q);
  assign reject     = (rd_q & wr_q) | ~acc_legal;
  // Reset wins over a completing store, so a store caught by reset never lands.
  assign we         = fire & wr_q & ~rd_q & ~reject & reset;

  load_align u_align (
    .word     (mem_word),
    .offset   (off_q),
    .funct3   (f3_q),
    .is_store (wr_q),
    .data     (ld_data),
    .byte_en  (byte_en),
    .legal    (acc_legal)
  );

  // Capture the request when it is accepted; held stable while BUSY
  always_ff @(posedge clk) begin
    if (start) begin
      idx_q   <= Addr[ADDR_W+1:2];
      off_q   <= Addr[1:0];
      f3_q    <= Funct3;
      wdata_q <= WrData;
      rd_q    <= MemRead;
      wr_q    <= MemWrite;
    end
  end

  // FSM, latency counter and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      RdData <= '0;
      Ready  <= 1'b0;
      Err    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          Ready <= 1'b0;
          Err   <= 1'b0;
          if (start) begin
            state <= BUSY;
            cnt   <= CNT_INIT;
          end
        end
        BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            Ready <= 1'b1;
            Err   <= reject;
            if (rd_q && !wr_q && !reject) begin
              RdData <= ld_data;
            end
            state <= DONE;
          end
        end
        DONE: begin
          Ready <= 1'b0;
          Err   <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // RAM write port with per-byte enables; contents survive reset
  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (byte_en[i]) begin
          mem[idx_q][8*i +: 8] <= wr_shifted[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: the driver pushes the expected
// completion edge, Err and RdData for each access; a negedge monitor pops and
// compares whenever Ready is seen.
module tb_data_mem_responder;

  localparam int LAT = 2;

  localparam logic [2:0] B  = 3'b000;
  localparam logic [2:0] H  = 3'b001;
  localparam logic [2:0] W  = 3'b010;
  localparam logic [2:0] BU = 3'b100;
  localparam logic [2:0] HU = 3'b101;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead;
  logic        MemWrite;
  logic [2:0]  Funct3;
  logic [31:0] Addr;
  logic [31:0] WrData;
  logic [31:0] RdData;
  logic        Ready;
  logic        Err;

  data_mem_responder #(.ADDR_W(9), .LATENCY(LAT)) dut (
    .clk      (clk),
    .reset    (reset),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .Funct3   (Funct3),
    .Addr     (Addr),
    .WrData   (WrData),
    .RdData   (RdData),
    .Ready    (Ready),
    .Err      (Err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          edge_n;
    logic        err;
    logic [31:0] rd;
    string       name;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] cur_rd = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: every Ready pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (reset === 1'b1 && Ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready at edge %0d (no access outstanding)", cyc);
      end else begin
        e = sb.pop_front();
        chk({e.name, "_edge"}, 32'(cyc), 32'(e.edge_n));
        chk({e.name, "_err"}, {31'h0, Err}, {31'h0, e.err});
        chk({e.name, "_rd"}, RdData, e.rd);
      end
    end
  end

  task automatic wait_ready(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (Ready !== 1'b1 && n < 40);
    if (Ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL timeout_%s actual=no_ready expected=ready", name);
    end
  endtask

  task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic exp_err, input logic [31:0] exp_rd,
                        input string name);
    exp_t x;
    @(negedge clk);
    MemRead  = rd;
    MemWrite = wr;
    Funct3   = f3;
    Addr     = a;
    WrData   = wd;
    x.edge_n = cyc + 1 + LAT;
    x.err    = exp_err;
    x.rd     = exp_rd;
    x.name   = name;
    sb.push_back(x);
    wait_ready(name);
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    @(negedge clk);
  endtask

  task automatic ld(input logic [2:0] f3, input logic [31:0] a,
                    input logic [31:0] exp, input string name);
    cur_rd = exp;
    access(1'b1, 1'b0, f3, a, 32'h0, 1'b0, exp, name);
  endtask

  task automatic st(input logic [2:0] f3, input logic [31:0] a,
                    input logic [31:0] wd, input string name);
    access(1'b0, 1'b1, f3, a, wd, 1'b0, cur_rd, name);
  endtask

  task automatic rej(input logic rd, input logic wr, input logic [2:0] f3,
                     input logic [31:0] a, input string name);
    access(rd, wr, f3, a, 32'hFFFF_FFFF, 1'b1, cur_rd, name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t x;
    int   s;
    reset    = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    Funct3   = 3'b000;
    Addr     = 32'h0;
    WrData   = 32'h0;
    repeat (3) @(negedge clk);
    chk("reset_rddata", RdData, 32'h0);
    chk("reset_ready", {31'h0, Ready}, 32'h0);
    chk("reset_err", {31'h0, Err}, 32'h0);
    reset = 1'b1;
    @(negedge clk);

    // 1: word store and load
    st(W, 32'h10, 32'hDEADBEEF, "sw_10");
    ld(W, 32'h10, 32'hDEADBEEF, "lw_10");

    // 2: sub-word loads with sign/zero extension
    ld(B,  32'h13, 32'hFFFFFFDE, "lb_13");
    ld(BU, 32'h13, 32'h000000DE, "lbu_13");
    ld(H,  32'h10, 32'hFFFFBEEF, "lh_10");
    ld(HU, 32'h12, 32'h0000DEAD, "lhu_12");

    // 3: byte store preserves neighbours
    st(B, 32'h11, 32'h00000055, "sb_11");
    ld(W, 32'h10, 32'hDEAD55EF, "lw_10_after_sb");
    ld(B, 32'h11, 32'h00000055, "lb_11");

    // 4: rejected accesses leave RAM and RdData alone
    rej(1'b1, 1'b0, W, 32'h12, "lw_misaligned");
    rej(1'b0, 1'b1, H, 32'h11, "sh_misaligned");
    rej(1'b1, 1'b1, W, 32'h10, "rd_and_wr");
    rej(1'b1, 1'b0, 3'b011, 32'h10, "ld_bad_f3");
    rej(1'b0, 1'b1, BU, 32'h10, "st_bad_f3");
    ld(W, 32'h10, 32'hDEAD55EF, "lw_10_after_rej");

    // 5: reset during BUSY drops the store
    st(W, 32'h14, 32'hCAFEF00D, "sw_14_old");
    @(negedge clk);
    MemWrite = 1'b1;
    Funct3   = W;
    Addr     = 32'h14;
    WrData   = 32'h12345678;
    @(negedge clk);
    MemWrite = 1'b0;
    reset    = 1'b0;
    @(negedge clk);
    chk("midreset_ready", {31'h0, Ready}, 32'h0);
    chk("midreset_rddata", RdData, 32'h0);
    @(negedge clk);
    reset  = 1'b1;
    cur_rd = 32'h0;
    repeat (4) @(negedge clk);
    ld(W, 32'h14, 32'hCAFEF00D, "lw_14_after_reset");

    // 6: aliasing beyond depth, then a request held through DONE
    st(W, 32'h810, 32'hA5A5A5A5, "sw_810");
    ld(W, 32'h010, 32'hA5A5A5A5, "lw_010_wrap");

    @(negedge clk);
    MemRead  = 1'b1;
    Funct3   = HU;
    Addr     = 32'h12;
    s        = cyc + 1;
    x.edge_n = s + LAT;
    x.err    = 1'b0;
    x.rd     = 32'h0000A5A5;
    x.name   = "hold_first";
    sb.push_back(x);
    x.edge_n = s + 2 * LAT + 2;
    x.name   = "hold_second";
    sb.push_back(x);
    while (cyc < s + LAT + 2) @(negedge clk);
    MemRead = 1'b0;
    wait_ready("hold_second");
    @(negedge clk);
    cur_rd = 32'h0000A5A5;

    repeat (6) @(negedge clk);
    chk("pending_after_run", 32'(sb.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
